// File: rtl/fx3_bus_pkg.sv
// Shared types and constants for the FX3 GPIF bus arbiter: state encoding,
// socket addresses, bus direction values and the round-robin pick helper.
package fx3_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_ADDR_SETUP = 3'd1,
    ST_GRANT_IN   = 3'd2,
    ST_GRANT_OUT  = 3'd3,
    ST_TURNAROUND = 3'd4
  } arb_state_t;

  typedef enum logic {
    SIDE_IN  = 1'b0,
    SIDE_OUT = 1'b1
  } side_t;

  localparam logic [1:0] IN_SOCKET  = 2'b00;
  localparam logic [1:0] OUT_SOCKET = 2'b11;

  localparam logic DIR_FX3_DRIVES  = 1'b0;
  localparam logic DIR_FPGA_DRIVES = 1'b1;

  // On a tie the side that was not served last wins.
  function automatic side_t pick_winner(input logic in_elig, input logic out_elig,
                                        input side_t last_served);
    if (in_elig && out_elig) begin
      return (last_served == SIDE_IN) ? SIDE_OUT : SIDE_IN;
    end else if (out_elig) begin
      return SIDE_OUT;
    end
    return SIDE_IN;
  endfunction

  function automatic logic [1:0] socket_for(input side_t side);
    return (side == SIDE_OUT) ? OUT_SOCKET : IN_SOCKET;
  endfunction

  function automatic logic dir_for(input side_t side);
    return (side == SIDE_OUT) ? DIR_FPGA_DRIVES : DIR_FX3_DRIVES;
  endfunction

endpackage

// File: rtl/fx3_arb_watchdog.sv
// Grant-length watchdog: counts enabled cycles since the last clear and flags
// the cycle in which the count reaches LIMIT-1.
module fx3_arb_watchdog #(
  parameter logic [15:0] LIMIT = 16'd4096
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  logic [15:0] count_reg;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count_reg <= 16'd0;
    end else if (enable) begin
      count_reg <= count_reg + 16'd1;
    end
  end

  assign expire = enable && (count_reg == LIMIT - 16'd1);

endmodule

// File: rtl/fx3_bus_arbiter.sv
// FX3 GPIF bus arbiter: one owner at a time, socket/direction setup and turnaround.
// Define FX3_ARB_WATCHDOG_EN to bound each grant to WDOG_CYCLES cycles.
module fx3_bus_arbiter
  import fx3_bus_pkg::*;
#(
  parameter int unsigned TURNAROUND_CYCLES = 2,
  parameter logic [15:0] WDOG_CYCLES       = 16'd4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_in_req,
  input  logic       i_in_ready,
  input  logic       i_in_done,
  output logic       o_in_grant,
  input  logic       i_out_req,
  input  logic       i_out_ready,
  input  logic       i_out_done,
  output logic       o_out_grant,
  output logic [1:0] o_socket_addr,
  output logic       o_bus_dir,
  output logic       o_busy,
  output logic       o_timeout
);

  localparam logic [3:0] TA_LOAD =
    (TURNAROUND_CYCLES == 0) ? 4'd0 : 4'(TURNAROUND_CYCLES - 1);
  localparam arb_state_t POST_GRANT =
    (TURNAROUND_CYCLES == 0) ? ST_IDLE : ST_TURNAROUND;

  arb_state_t state_reg;
  side_t      last_served_reg;
  side_t      winner;
  logic [3:0] ta_count_reg;
  logic [1:0] socket_addr_reg;
  logic       bus_dir_reg;
  logic       in_elig;
  logic       out_elig;
  logic       granted;
  logic       owner_done;
  logic       wdog_expire;
  logic       grant_end;

  assign in_elig    = i_in_req & i_in_ready;
  assign out_elig   = i_out_req & i_out_ready;
  assign winner     = pick_winner(in_elig, out_elig, last_served_reg);
  assign granted    = (state_reg == ST_GRANT_IN) || (state_reg == ST_GRANT_OUT);
  // Only the owning side's done counts; the other side's is ignored.
  assign owner_done = ((state_reg == ST_GRANT_IN)  && i_in_done) ||
                      ((state_reg == ST_GRANT_OUT) && i_out_done);
  assign grant_end  = owner_done || (granted && wdog_expire);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= ST_IDLE;
      last_served_reg <= SIDE_OUT;
      ta_count_reg    <= 4'd0;
      socket_addr_reg <= IN_SOCKET;
      bus_dir_reg     <= DIR_FX3_DRIVES;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (in_elig || out_elig) begin
            state_reg       <= ST_ADDR_SETUP;
            last_served_reg <= winner;
            socket_addr_reg <= socket_for(winner);
            bus_dir_reg     <= dir_for(winner);
          end
        end
        ST_ADDR_SETUP: begin
          state_reg <= (last_served_reg == SIDE_OUT) ? ST_GRANT_OUT : ST_GRANT_IN;
        end
        ST_GRANT_IN, ST_GRANT_OUT: begin
          if (grant_end) begin
            state_reg    <= POST_GRANT;
            ta_count_reg <= TA_LOAD;
            // With no turnaround the direction is left alone until the next setup.
            if (POST_GRANT == ST_TURNAROUND) begin
              bus_dir_reg <= DIR_FX3_DRIVES;
            end
          end
        end
        ST_TURNAROUND: begin
          if (ta_count_reg == 4'd0) begin
            state_reg <= ST_IDLE;
          end else begin
            ta_count_reg <= ta_count_reg - 4'd1;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef FX3_ARB_WATCHDOG_EN
  logic timeout_reg;

  fx3_arb_watchdog #(
    .LIMIT (WDOG_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (state_reg == ST_ADDR_SETUP),
    .enable (granted),
    .expire (wdog_expire)
  );

  // A done arriving in the expiry cycle wins, so no pulse then.
  always_ff @(posedge clk) begin
    if (rst) begin
      timeout_reg <= 1'b0;
    end else begin
      timeout_reg <= granted && wdog_expire && !owner_done;
    end
  end

  assign o_timeout = timeout_reg;
`else
  assign wdog_expire = 1'b0;
  assign o_timeout   = 1'b0;
`endif

  assign o_in_grant    = (state_reg == ST_GRANT_IN);
  assign o_out_grant   = (state_reg == ST_GRANT_OUT);
  assign o_busy        = (state_reg != ST_IDLE);
  assign o_socket_addr = socket_addr_reg;
  assign o_bus_dir     = bus_dir_reg;

endmodule
